// File: rtl/mux_3_1_arbiter.sv
// mux_3_1_arbiter: round-robin 3-to-1 select with a single registered output
// slot under a valid/ready handshake.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | output register empty, out_valid = 0
//   FULL  | out_data holds a word not yet accepted, out_valid = 1
//
module mux_3_1_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] in_00,
    input  logic [WIDTH-1:0] in_01,
    input  logic [WIDTH-1:0] in_10,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       gnt_q, gnt_d;

    logic             cap;
    logic [1:0]       win;
    logic [1:0]       pri_0, pri_1, pri_2;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin winner: last+1 first, then last+2, the previous winner last.
    always_comb begin
        pri_0 = inc3(last_q);
        pri_1 = inc3(pri_0);
        pri_2 = last_q;
        win   = pri_2;
        if (req[pri_0]) begin
            win = pri_0;
        end else if (req[pri_1]) begin
            win = pri_1;
        end
    end

    // A new word may enter when the slot is empty or is being emptied this edge.
    assign cap = ((state_q == IDLE) || out_ready) && (|req);

    // Next-state, capture and grant pulse.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        data_d  = data_q;
        gnt_d   = 3'b000;
        if (cap) begin
            state_d = FULL;
            last_d  = win;
            sel_d   = win;
            gnt_d   = 3'b001 << win;
            case (win)
                2'd0:    data_d = in_00;
                2'd1:    data_d = in_01;
                default: data_d = in_10;
            endcase
        end else if ((state_q == FULL) && out_ready) begin
            state_d = IDLE;
        end
    end

    // State registers; reset discards any held word and gives port 00 first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            sel_q   <= 2'd0;
            data_q  <= '0;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = (state_q == FULL);
    assign busy      = (state_q == FULL);

endmodule

// File: tb/tb_mux_3_1_arbiter.sv
// Directed bench for mux_3_1_arbiter: one task per scenario, inline checks.
module tb_mux_3_1_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [31:0] in_00, in_01, in_10;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mux_3_1_arbiter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_00     (in_00),
        .in_01     (in_01),
        .in_10     (in_10),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 3'b000; out_ready = 1'b0;
        in_00 = 32'h0; in_01 = 32'h0; in_10 = 32'h0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (gnt !== 3'b000)     begin n_err++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        n_cmp++; if (sel !== 2'b00)      begin n_err++; $display("FAIL reset_sel got=%b exp=00", sel); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data); end
    endtask

    task automatic test_single();
        req = 3'b001; in_00 = 32'h1111_1111; out_ready = 1'b1;
        step();
        req = 3'b000;
        n_cmp++; if (gnt !== 3'b001)            begin n_err++; $display("FAIL single_gnt got=%b exp=001", gnt); end
        n_cmp++; if (sel !== 2'b00)             begin n_err++; $display("FAIL single_sel got=%b exp=00", sel); end
        n_cmp++; if (out_data !== 32'h1111_1111) begin n_err++; $display("FAIL single_data got=%h exp=11111111", out_data); end
        n_cmp++; if (out_valid !== 1'b1)        begin n_err++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        n_cmp++; if (busy !== 1'b1)             begin n_err++; $display("FAIL single_busy got=%b exp=1", busy); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drop_valid got=%b exp=0", out_valid); end
        n_cmp++; if (gnt !== 3'b000)     begin n_err++; $display("FAIL single_drop_gnt got=%b exp=000", gnt); end
    endtask

    task automatic test_rotation();
        logic [1:0]  exp_sel [5];
        logic [2:0]  exp_gnt [5];
        logic [31:0] exp_dat [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_dat = '{32'hA, 32'hB, 32'hC, 32'hA, 32'hB};
        pulse_reset();
        in_00 = 32'hA; in_01 = 32'hB; in_10 = 32'hC;
        req = 3'b111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (sel !== exp_sel[i])      begin n_err++; $display("FAIL rot_sel[%0d] got=%0d exp=%0d", i, sel, exp_sel[i]); end
            n_cmp++; if (gnt !== exp_gnt[i])      begin n_err++; $display("FAIL rot_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt[i]); end
            n_cmp++; if (out_data !== exp_dat[i]) begin n_err++; $display("FAIL rot_data[%0d] got=%h exp=%h", i, out_data, exp_dat[i]); end
            n_cmp++; if (out_valid !== 1'b1)      begin n_err++; $display("FAIL rot_valid[%0d] got=%b exp=1", i, out_valid); end
        end
        req = 3'b000;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rot_end_valid got=%b exp=0", out_valid); end
    endtask

    // Last winner is port 01 going in (rotation ended on 01).
    task automatic test_backpressure();
        req = 3'b010; in_01 = 32'hDEAD_BEEF; out_ready = 1'b1;
        step();
        n_cmp++; if (gnt !== 3'b010)             begin n_err++; $display("FAIL bp_cap_gnt got=%b exp=010", gnt); end
        n_cmp++; if (out_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bp_cap_data got=%h exp=deadbeef", out_data); end
        out_ready = 1'b0; req = 3'b101;
        in_00 = 32'h0000_0A0A; in_10 = 32'h1010_1010;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (out_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bp_hold_data[%0d] got=%h exp=deadbeef", i, out_data); end
            n_cmp++; if (sel !== 2'b01)              begin n_err++; $display("FAIL bp_hold_sel[%0d] got=%b exp=01", i, sel); end
            n_cmp++; if (out_valid !== 1'b1)         begin n_err++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
            n_cmp++; if (gnt !== 3'b000)             begin n_err++; $display("FAIL bp_hold_gnt[%0d] got=%b exp=000", i, gnt); end
        end
        out_ready = 1'b1;
        step();
        req = 3'b000;
        n_cmp++; if (gnt !== 3'b100)             begin n_err++; $display("FAIL bp_next_gnt got=%b exp=100", gnt); end
        n_cmp++; if (sel !== 2'b10)              begin n_err++; $display("FAIL bp_next_sel got=%b exp=10", sel); end
        n_cmp++; if (out_data !== 32'h1010_1010) begin n_err++; $display("FAIL bp_next_data got=%h exp=10101010", out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 32'hB2B0_0000 + i;
            if (i % 2 == 0) begin
                req = 3'b010; in_01 = d;
            end else begin
                req = 3'b100; in_10 = d;
            end
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
            n_cmp++; if (out_data !== d)     begin n_err++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, d); end
            n_cmp++; if (gnt !== ((i % 2 == 0) ? 3'b010 : 3'b100))
                begin n_err++; $display("FAIL b2b_gnt[%0d] got=%b", i, gnt); end
        end
    endtask

    // Entered with a word held from port 10 and out_ready = 1.
    task automatic test_idle();
        req = 3'b000; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, out_valid); end
            n_cmp++; if (gnt !== 3'b000)     begin n_err++; $display("FAIL idle_gnt[%0d] got=%b exp=000", i, gnt); end
            n_cmp++; if (sel !== 2'b10)      begin n_err++; $display("FAIL idle_sel[%0d] got=%b exp=10", i, sel); end
        end
    endtask

    task automatic test_reset_mid();
        req = 3'b010; in_01 = 32'h5555_AAAA; out_ready = 1'b1;
        step();
        req = 3'b111; out_ready = 1'b0;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        n_cmp++; if (sel !== 2'b00)      begin n_err++; $display("FAIL rmid_sel got=%b exp=00", sel); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rmid_data got=%h exp=0", out_data); end
        n_cmp++; if (gnt !== 3'b000)     begin n_err++; $display("FAIL rmid_gnt got=%b exp=000", gnt); end
        in_00 = 32'h0C0C_0C0C; out_ready = 1'b1;
        step();
        req = 3'b000;
        n_cmp++; if (gnt !== 3'b001)             begin n_err++; $display("FAIL rmid_post_gnt got=%b exp=001", gnt); end
        n_cmp++; if (out_data !== 32'h0C0C_0C0C) begin n_err++; $display("FAIL rmid_post_data got=%h exp=0c0c0c0c", out_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_3_1_arbiter.md
# mux_3_1_arbiter

Round-robin arbiter and sequencer for a 32-bit 3-to-1 datapath select, sharing one downstream consumer between three requesters. Port 00, port 01 and port 10 each present a request and a data word. The block grants one winner at a time, drives the 2-bit select code, and captures the selected word into an output register. It then holds that word under a valid/ready handshake until the consumer accepts it.

## Interface
- `WIDTH`, default 32: data width of every input and the output.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req`  input  3  request per port; bit 0 = port 00, bit 1 = port 01, bit 2 = port 10.
- `in_00`  input  WIDTH  data for port 00.
- `in_01`  input  WIDTH  data for port 01.
- `in_10`  input  WIDTH  data for port 10.
- `gnt`  output  3  one-hot, one-cycle pulse marking the port whose word was captured.
- `sel`  output  2  select code of the last winner (00/01/10); never 11.
- `out_data`  output  WIDTH  registered captured word.
- `out_valid`  output  1  `out_data` holds an unaccepted word.
- `out_ready`  input  1  consumer accepts `out_data` when high together with `out_valid`.
- `busy`  output  1  equals `out_valid`; provided for the core's stall logic.

## Operation
- FSM states:
  - IDLE: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- Capture condition `cap` = (IDLE or (FULL and `out_ready`)) and |`req`.
- IDLE transitions:
  - IDLE -> FULL on `cap`.
  - IDLE -> IDLE otherwise.
- FULL transitions:
  - FULL -> FULL while `out_ready` = 0, with output held.
  - FULL -> FULL on accept with `cap` (back-to-back transfer).
  - FULL -> IDLE on accept without any `req`.
- Round-robin pointer `last` (2 bits, values 0..2) holds the last winner.
  - Priority order is `last`+1, `last`+2, `last`, each modulo 3.
  - Winner index w: `sel` <= w, `out_data` <= in_w, `gnt` <= one-hot(w) for exactly one cycle, `last` <= w.
- A requester seeing its `gnt` bit high must, in that same cycle, deassert `req` or present its next word. Its current word has been consumed.
- `sel` holds its value between captures.
- `out_data` is stable and unchanged while `out_valid` = 1 and `out_ready` = 0.
- Requests arriving while FULL and not accepted are not captured; there is no queueing beyond the single output register.
- A port that requests continuously is served at most once per three captures while the other ports request. There is no starvation.

## Timing
- Reset (`rst_n` = 0 at an edge) values:
  - FSM = IDLE; `out_valid` = 0; `busy` = 0; `gnt` = 000.
  - `sel` = 00; `out_data` = 0.
  - `last` = 2, so port 00 has top priority first.
- Reset dominates every other input, including mid-transaction. A held word is discarded and not presented after reset.
- Latency: `req` high in cycle N from IDLE -> `gnt`, `sel`, `out_data` and `out_valid` all updated in cycle N+1.
- Throughput: one word per cycle when `out_ready` stays high and requests are pending.
- Accept and new capture on the same edge: `out_valid` stays 1, `out_data` is replaced, and the new `gnt` pulses in the next cycle.
- Accept without a pending request: `out_valid` falls at the next edge; `gnt` = 000.
- `gnt` is never asserted in a cycle without a capture on the preceding edge. At most one `gnt` bit is high.
- `req` = 000 in IDLE: no state change; `sel` keeps its last value.

## Test plan
- Single request:
  - Stimulus: `req` = 001, `in_00` = 0x1111_1111, `out_ready` = 1.
  - Required response: next cycle `gnt` = 001, `sel` = 00, `out_data` = 0x1111_1111, `out_valid` = 1. One cycle later `out_valid` = 0 once `req` is dropped.
- Rotation:
  - Stimulus: `req` = 111 held, inputs 0xA, 0xB, 0xC, `out_ready` = 1.
  - Required response: captures in order 00, 01, 10, 00, 01, with `sel` sequence 00, 01, 10, 00, 01 on consecutive cycles.
- Backpressure:
  - Stimulus: capture 0xDEAD_BEEF from port 01, then `out_ready` = 0 for 5 cycles with `req` = 101.
  - Required response: `out_data`, `sel` = 01 and `out_valid` = 1 are stable with no `gnt` pulse. When `out_ready` = 1, the next capture goes to port 10.
- Back-to-back:
  - Stimulus: `out_ready` = 1 with requests alternating 010 and 100 every cycle.
  - Required response: `out_valid` stays 1 throughout, with one new word per cycle.
- Reset mid-operation:
  - Stimulus: hold FULL with `out_ready` = 0, then assert `rst_n` = 0 for one edge.
  - Required response: `out_valid` = 0, `sel` = 00, `out_data` = 0, `gnt` = 000. The next request from `req` = 111 grants port 00.
- Idle:
  - Stimulus: `req` = 000 for 10 cycles after any capture and accept.
  - Required response: `out_valid` = 0, `gnt` = 000, and `sel` unchanged.
